crc_engine_param: RTL and testbench

- Parametrised successor to the fixed CRC-16/8-byte CRC block in the serial security wrapper.
- Bit-serial CRC engine with configurable CRC width, polynomial, data word width and frame length.
- Valid/ready input handshake; runtime seed.
- Two modes: generate (serialise CRC out in OUT_W chunks) and check (compare computed CRC against a CRC appended to the frame; flag pass/fail).

---
 rtl/crc_engine_param_if.sv | 32 +++
 rtl/crc_engine_param.sv | 191 +++++++++++++++++++
 tb/tb_crc_engine_param.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_engine_param_if.sv
// Handshake and result bundle for crc_engine_param: frame control, input word
// stream and CRC/verdict outputs. The engine is the slave, the frame source
// is the master.
interface crc_engine_param_if #(
    parameter int unsigned CRC_W  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 8
);
    logic              start;
    logic              check_mode;
    logic [CRC_W-1:0]  seed;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              crc_valid;
    logic [OUT_W-1:0]  crc_out;
    logic              crc_last;
    logic              frame_done;
    logic              crc_ok;
    logic              crc_err;

    modport slave (
        input  start, check_mode, seed, in_valid, in_data,
        output in_ready, busy, crc_valid, crc_out, crc_last, frame_done, crc_ok, crc_err
    );

    modport master (
        output start, check_mode, seed, in_valid, in_data,
        input  in_ready, busy, crc_valid, crc_out, crc_last, frame_done, crc_ok, crc_err
    );
endinterface

// File: rtl/crc_engine_param.sv
// crc_engine_param: bit-serial, MSB-first CRC engine with runtime seed.
// Generate mode streams the CRC out least-significant chunk first; check mode
// takes the received CRC (most-significant word first) after the payload and
// reports match/mismatch. No reflection and no final XOR.
// Legal parameters: CRC_W >= DATA_W, CRC_W % DATA_W == 0, CRC_W % OUT_W == 0,
// FRAME_LEN in 1..255.
module crc_engine_param #(
    parameter int unsigned      CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(16'h1021),
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      FRAME_LEN = 8,
    parameter int unsigned      OUT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    crc_engine_param_if.slave  bus
);

    localparam int unsigned NumRxWords = CRC_W / DATA_W;
    localparam int unsigned NumChunks  = CRC_W / OUT_W;
    localparam int unsigned BitCntW    = $clog2(DATA_W) + 1;

    localparam logic [7:0]         FrameLenCnt  = 8'(FRAME_LEN);
    localparam logic [7:0]         LastRxIdx    = 8'(NumRxWords - 1);
    localparam logic [7:0]         LastChunkIdx = 8'(NumChunks - 1);
    localparam logic [BitCntW-1:0] LastBit      = BitCntW'(DATA_W - 1);

    // StDone is the single end-of-frame cycle: compare result in check mode,
    // the pulse after the last chunk in generate mode.
    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StShift,
        StRxCrc,
        StEmit,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   rx_q, rx_d;
    logic               mode_q, mode_d;
    logic [7:0]         word_cnt_q, word_cnt_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]         word_inc;

    logic               crc_valid_q, crc_valid_d;
    logic [OUT_W-1:0]   crc_out_q, crc_out_d;
    logic               crc_last_q, crc_last_d;
    logic               frame_done_q, frame_done_d;
    logic               crc_ok_q, crc_ok_d;
    logic               crc_err_q, crc_err_d;

    // Next-state, datapath and registered-output decode.
    // word_cnt counts payload words, then is reused for received-CRC words
    // (check) or emitted chunks (generate).
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        rx_d         = rx_q;
        mode_d       = mode_q;
        word_cnt_d   = word_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        crc_valid_d  = 1'b0;
        crc_out_d    = '0;
        crc_last_d   = 1'b0;
        frame_done_d = 1'b0;
        crc_ok_d     = 1'b0;
        crc_err_d    = 1'b0;
        word_inc     = word_cnt_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    crc_d      = bus.seed;
                    rx_d       = '0;
                    mode_d     = bus.check_mode;
                    word_cnt_d = '0;
                    state_d    = StAccept;
                end
            end

            StAccept: begin
                if (bus.in_valid) begin
                    crc_d     = crc_q ^ (CRC_W'(bus.in_data) << (CRC_W - DATA_W));
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end

            StShift: begin
                crc_d     = crc_q[CRC_W-1] ? ((crc_q << 1) ^ POLY) : (crc_q << 1);
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                if (bit_cnt_q == LastBit) begin
                    if (word_inc < FrameLenCnt) begin
                        word_cnt_d = word_inc;
                        state_d    = StAccept;
                    end else begin
                        word_cnt_d = '0;
                        if (mode_q) begin
                            state_d = StRxCrc;
                        end else begin
                            // Load chunk 0 now so it is visible in the first EMIT cycle.
                            state_d     = StEmit;
                            crc_valid_d = 1'b1;
                            crc_out_d   = crc_d[OUT_W-1:0];
                            crc_last_d  = (NumChunks == 1);
                        end
                    end
                end
            end

            StRxCrc: begin
                if (bus.in_valid) begin
                    rx_d = (rx_q << DATA_W) | CRC_W'(bus.in_data);
                    if (word_cnt_q == LastRxIdx) begin
                        state_d      = StDone;
                        word_cnt_d   = '0;
                        frame_done_d = 1'b1;
                        crc_ok_d     = (rx_d == crc_q);
                        crc_err_d    = (rx_d != crc_q);
                    end else begin
                        word_cnt_d = word_inc;
                    end
                end
            end

            StEmit: begin
                if (word_cnt_q == LastChunkIdx) begin
                    state_d      = StDone;
                    word_cnt_d   = '0;
                    frame_done_d = 1'b1;
                end else begin
                    word_cnt_d  = word_inc;
                    crc_valid_d = 1'b1;
                    crc_out_d   = crc_q[32'(word_inc) * OUT_W +: OUT_W];
                    crc_last_d  = (word_inc == LastChunkIdx);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            crc_q        <= '0;
            rx_q         <= '0;
            mode_q       <= 1'b0;
            word_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            crc_valid_q  <= 1'b0;
            crc_out_q    <= '0;
            crc_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            rx_q         <= rx_d;
            mode_q       <= mode_d;
            word_cnt_q   <= word_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            crc_valid_q  <= crc_valid_d;
            crc_out_q    <= crc_out_d;
            crc_last_q   <= crc_last_d;
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign bus.in_ready   = (state_q == StAccept) || (state_q == StRxCrc);
    assign bus.busy       = (state_q != StIdle);
    assign bus.crc_valid  = crc_valid_q;
    assign bus.crc_out    = crc_out_q;
    assign bus.crc_last   = crc_last_q;
    assign bus.frame_done = frame_done_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.crc_err    = crc_err_q;

endmodule

// File: tb/tb_crc_engine_param.sv
// Scoreboard bench for crc_engine_param: a CRC-16 instance (OUT_W 8) and a
// CRC-32 instance (OUT_W 16), both FRAME_LEN 9. Expected chunks/verdicts are
// queued when a frame is issued; per-instance monitors pop on crc_valid and
// frame_done.
module tb_crc_engine_param;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_engine_param_if #(.CRC_W(16), .DATA_W(8), .OUT_W(8))  b16 ();
    crc_engine_param_if #(.CRC_W(32), .DATA_W(8), .OUT_W(16)) b32 ();

    crc_engine_param #(
        .CRC_W(16), .POLY(16'h1021), .DATA_W(8), .FRAME_LEN(9), .OUT_W(8)
    ) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(b16.slave)
    );

    crc_engine_param #(
        .CRC_W(32), .POLY(32'h04C11DB7), .DATA_W(8), .FRAME_LEN(9), .OUT_W(16)
    ) dut32 (
        .clk(clk), .reset_n(reset_n), .bus(b32.slave)
    );

    // kind: 0 = chunk, 1 = generate frame_done, 2 = check frame_done
    typedef struct {
        int          kind;
        logic [31:0] val;
        logic        last;
        logic        ok;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: polynomial division one message bit at a time.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] seed, input logic [7:0] msg[$]);
        logic [31:0] mask;
        logic [31:0] crc;
        logic        fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        crc  = seed & mask;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[w-1] ^ msg[i][b];
                crc = (crc << 1) & mask;
                if (fb) crc = crc ^ poly;
            end
        end
        return crc;
    endfunction

    // Scoreboard monitors: sample mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            checks++;
            if ((b16.in_ready && !b16.busy) || (b16.in_ready && (b16.crc_valid || b16.frame_done))
                || ((b16.crc_ok || b16.crc_err) && !b16.frame_done)) begin
                errors++;
                $display("FAIL invariant16: in_ready=%b busy=%b valid=%b done=%b ok=%b err=%b",
                         b16.in_ready, b16.busy, b16.crc_valid, b16.frame_done,
                         b16.crc_ok, b16.crc_err);
            end
            if (b16.crc_valid) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL chunk16: got unexpected chunk 0x%0h, expected none", b16.crc_out);
                end else begin
                    e = q16.pop_front();
                    if (e.kind != 0 || b16.crc_out !== e.val[7:0] || b16.crc_last !== e.last) begin
                        errors++;
                        $display("FAIL chunk16: got 0x%0h last=%b expected kind=%0d 0x%0h last=%b",
                                 b16.crc_out, b16.crc_last, e.kind, e.val[7:0], e.last);
                    end
                end
            end
            if (b16.frame_done) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL done16: got unexpected frame_done, expected none");
                end else begin
                    e = q16.pop_front();
                    if (e.kind == 0 || b16.crc_ok !== (e.kind == 2 && e.ok)
                        || b16.crc_err !== (e.kind == 2 && !e.ok)) begin
                        errors++;
                        $display("FAIL done16: got ok=%b err=%b expected kind=%0d ok=%b",
                                 b16.crc_ok, b16.crc_err, e.kind, e.ok);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (b32.crc_valid) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL chunk32: got unexpected chunk 0x%0h, expected none", b32.crc_out);
                end else begin
                    e = q32.pop_front();
                    if (e.kind != 0 || b32.crc_out !== e.val[15:0] || b32.crc_last !== e.last) begin
                        errors++;
                        $display("FAIL chunk32: got 0x%0h last=%b expected kind=%0d 0x%0h last=%b",
                                 b32.crc_out, b32.crc_last, e.kind, e.val[15:0], e.last);
                    end
                end
            end
            if (b32.frame_done) begin
                checks++;
                if (q32.size() == 0 || q32[0].kind != 1 || b32.crc_ok || b32.crc_err) begin
                    errors++;
                    $display("FAIL done32: got frame_done ok=%b err=%b, expected generate done",
                             b32.crc_ok, b32.crc_err);
                end
                if (q32.size() != 0) void'(q32.pop_front());
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy16"}, 32'(b16.busy), 0);
        chk({tag, " in_ready16"}, 32'(b16.in_ready), 0);
        chk({tag, " crc_valid16"}, 32'(b16.crc_valid), 0);
        chk({tag, " crc_out16"}, 32'(b16.crc_out), 0);
        chk({tag, " crc_last16"}, 32'(b16.crc_last), 0);
        chk({tag, " flags16"}, {29'd0, b16.frame_done, b16.crc_ok, b16.crc_err}, 0);
        chk({tag, " busy32"}, 32'(b32.busy), 0);
        chk({tag, " outs32"}, {b32.crc_out, 12'd0, b32.crc_valid, b32.crc_last,
                               b32.frame_done, b32.crc_ok}, 0);
    endtask

    task automatic send16(input logic [7:0] d, output int hs);
        int n = 0;
        b16.in_valid = 1'b1;
        b16.in_data  = d;
        while (!b16.in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!b16.in_ready) begin
            errors++;
            $display("FAIL handshake16: got in_ready=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        hs = cyc;
        b16.in_valid = 1'b0;
        b16.in_data  = 8'($urandom);
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (b16.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("frame end16 busy", 32'(b16.busy), 0);
    endtask

    // One CRC-16 frame. max_gap adds random idle cycles (with stray start
    // pulses) before each word; abort_after > 0 resets after that many words.
    task automatic run16(input logic [15:0] seed, input bit mode, input logic [7:0] msg[$],
                         input logic [7:0] rx[$], input int max_gap, input int abort_after,
                         input bit check_rate, input logic [31:0] exp_crc, input bit use_exp);
        logic [31:0] c;
        int          hs, prev_hs, gap;
        c = use_exp ? exp_crc : ref_crc(16, 32'h1021, 32'(seed), msg);
        if (abort_after <= 0) begin
            if (!mode) begin
                q16.push_back('{kind: 0, val: c & 32'hFF, last: 1'b0, ok: 1'b0});
                q16.push_back('{kind: 0, val: c >> 8, last: 1'b1, ok: 1'b0});
                q16.push_back('{kind: 1, val: 0, last: 1'b0, ok: 1'b0});
            end else begin
                q16.push_back('{kind: 2, val: 0, last: 1'b0, ok: ({rx[0], rx[1]} == c[15:0])});
            end
        end
        b16.start = 1'b1; b16.check_mode = mode; b16.seed = seed;
        @(posedge clk); #1;
        b16.start = 1'b0;
        chk("start busy16", 32'(b16.busy), 1);
        prev_hs = 0;
        for (int i = 0; i < msg.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                b16.start      = 1'($urandom_range(0, 1));
                b16.check_mode = 1'($urandom_range(0, 1));
                b16.seed       = 16'($urandom);
                @(posedge clk); #1;
            end
            b16.start = 1'b0;
            send16(msg[i], hs);
            if (check_rate && i > 0) chk("accept spacing16", 32'(hs - prev_hs), 9);
            prev_hs = hs;
            if (abort_after > 0 && i == abort_after - 1) begin
                @(posedge clk); #1;
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                check_idle_outputs("abort");
                return;
            end
        end
        if (mode) begin
            for (int i = 0; i < rx.size(); i++) send16(rx[i], hs);
        end
        wait_idle16();
    endtask

    task automatic run32(input logic [31:0] seed, input logic [7:0] msg[$],
                         input logic [31:0] exp_crc, input bit use_exp);
        logic [31:0] c;
        int          n;
        c = use_exp ? exp_crc : ref_crc(32, 32'h04C11DB7, seed, msg);
        q32.push_back('{kind: 0, val: c & 32'hFFFF, last: 1'b0, ok: 1'b0});
        q32.push_back('{kind: 0, val: c >> 16, last: 1'b1, ok: 1'b0});
        q32.push_back('{kind: 1, val: 0, last: 1'b0, ok: 1'b0});
        b32.start = 1'b1; b32.check_mode = 1'b0; b32.seed = seed;
        @(posedge clk); #1;
        b32.start = 1'b0;
        for (int i = 0; i < msg.size(); i++) begin
            n = 0;
            b32.in_valid = 1'b1;
            b32.in_data  = msg[i];
            while (!b32.in_ready && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (!b32.in_ready) begin
                errors++;
                $display("FAIL handshake32: got in_ready=0, expected 1");
            end
            @(posedge clk); #1;
            b32.in_valid = 1'b0;
        end
        n = 0;
        while (b32.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("frame end32 busy", 32'(b32.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  msg[$];
        logic [7:0]  rmsg[$];
        logic [7:0]  rx[$];
        logic [7:0]  none[$];
        logic [31:0] c;
        logic [15:0] s;
        bit          m;

        reset_n = 1'b0;
        b16.start = 1'b0; b16.check_mode = 1'b0; b16.seed = '0;
        b16.in_valid = 1'b0; b16.in_data = '0;
        b32.start = 1'b0; b32.check_mode = 1'b0; b32.seed = '0;
        b32.in_valid = 1'b0; b32.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        run16(16'hFFFF, 1'b0, msg, none, 0, 0, 1'b1, 32'h29B1, 1'b1);
        run16(16'h0000, 1'b0, msg, none, 0, 0, 1'b0, 32'h31C3, 1'b1);
        rx = '{8'h29, 8'hB1};
        run16(16'hFFFF, 1'b1, msg, rx, 0, 0, 1'b0, 32'h29B1, 1'b1);
        rx = '{8'h29, 8'hB0};
        run16(16'hFFFF, 1'b1, msg, rx, 0, 0, 1'b0, 32'h29B1, 1'b1);
        run16(16'hFFFF, 1'b0, msg, none, 5, 0, 1'b0, 32'h29B1, 1'b1);
        run16(16'hFFFF, 1'b0, msg, none, 0, 4, 1'b0, 32'h29B1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        run16(16'hFFFF, 1'b0, msg, none, 0, 0, 1'b0, 32'h29B1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            rmsg.delete();
            for (int i = 0; i < 9; i++) rmsg.push_back(8'($urandom));
            s = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            c = ref_crc(16, 32'h1021, 32'(s), rmsg);
            if ($urandom_range(0, 1) == 1) c = c ^ (32'd1 << $urandom_range(0, 15));
            rx = '{c[15:8], c[7:0]};
            run16(s, m, rmsg, rx, 5, 0, 1'b0, 32'h0, 1'b0);
        end

        run32(32'hFFFF_FFFF, msg, 32'h0376_E6E7, 1'b1);
        for (int t = 0; t < 3; t++) begin
            rmsg.delete();
            for (int i = 0; i < 9; i++) rmsg.push_back(8'($urandom));
            run32($urandom, rmsg, 32'h0, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard16 drained", 32'(q16.size()), 0);
        chk("scoreboard32 drained", 32'(q32.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
